// File: rtl/rf_wb_arb.sv
// rf_wb_arb: write-port arbiter for the register file.
// It shares the single write port between the ALU writeback (port 0, which
// has priority) and the memory/load writeback (port 1). Port 1 is forced
// to win after STARVE_LIM consecutive denials. Writes to R0 complete their
// handshake but are dropped.
//
// Handshake: a request transfers when vldN && rdyN are both high at posedge.
// A requester holds addrN/dataN stable while vldN && !rdyN. rdyN is never
// high without vldN, and rdy0/rdy1 are never high in the same cycle.
module rf_wb_arb #(
    parameter int DW         = 16,
    parameter int AW         = 4,
    parameter int STARVE_LIM = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          vld0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] data0,
    output logic          rdy0,
    input  logic          vld1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] data1,
    output logic          rdy1,
    output logic          we,
    output logic [AW-1:0] dst_addr,
    output logic [DW-1:0] dst,
    output logic [3:0]    starve_cnt,
    output logic          arb_state
);

    typedef enum logic {PRI0 = 1'b0, FORCE1 = 1'b1} state_t;

    localparam logic [3:0] LIM    = 4'(STARVE_LIM);
    localparam logic [3:0] LIM_M1 = 4'(STARVE_LIM - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] dst_q;

    // Grant: port 0 wins contention unless port 1 is being forced through.
    always_comb begin
        rdy0 = 1'b0;
        rdy1 = 1'b0;
        if (rst_n) begin
            if (vld0 && (!vld1 || state_q == PRI0)) begin
                rdy0 = 1'b1;
            end else if (vld1) begin
                rdy1 = 1'b1;
            end
        end
    end

    // Next state and starvation count for port 1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!vld1 || rdy1) begin
            cnt_d = 4'd0;
        end else if (cnt_q != LIM) begin
            cnt_d = cnt_q + 4'd1;
        end
        case (state_q)
            PRI0: begin
                if (vld1 && !rdy1 && cnt_q == LIM_M1) begin
                    state_d = FORCE1;
                end
            end
            FORCE1: begin
                // Leave once port 1 transfers or withdraws its request.
                if (!vld1 || rdy1) begin
                    state_d = PRI0;
                end
            end
            default: state_d = PRI0;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= PRI0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Registered write beat; R0 writes are accepted but never reach the file.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            dst_q  <= '0;
        end else if (rdy0 && addr0 != '0) begin
            we_q   <= 1'b1;
            addr_q <= addr0;
            dst_q  <= data0;
        end else if (rdy1 && addr1 != '0) begin
            we_q   <= 1'b1;
            addr_q <= addr1;
            dst_q  <= data1;
        end else begin
            we_q   <= 1'b0;
        end
    end

    assign we         = we_q;
    assign dst_addr   = addr_q;
    assign dst        = dst_q;
    assign starve_cnt = cnt_q;
    assign arb_state  = state_q;

endmodule
